// File: rtl/rule110_stream_tx.sv
// Rule 110 cellular-automaton engine with a byte-serial seed port and a
// valid/ready byte-stream transmitter. The current generation is sent
// LSB byte first, then each requested successor generation follows after
// a single evolution cycle.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | accepting seed bytes, waiting for start
//   S_SEND | presenting one byte per handshake of the current generation
//   S_STEP | one cycle: evolve cells to the next generation
module rule110_stream_tx #(
  parameter int CELLS = 32,
  parameter bit WRAP  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_seed_valid,
  input  logic [7:0] i_seed_byte,
  output logic       o_seed_ready,
  input  logic       i_start,
  input  logic [7:0] i_gens,
  output logic       o_out_valid,
  output logic [7:0] o_out_byte,
  output logic       o_out_last,
  input  logic       i_out_ready,
  output logic       o_busy
);

  localparam int NBYTES = CELLS / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t           r_state;
  logic [CELLS-1:0] r_cells;
  logic [IDXW-1:0]  r_idx;
  logic [7:0]       r_remaining;
  logic             r_out_valid;
  logic [7:0]       r_out_byte;
  logic             r_out_last;
  logic             r_busy;
  logic             r_seed_ready;

  logic [CELLS-1:0] w_seed_shift;
  logic [CELLS-1:0] w_gen0;
  logic [CELLS+1:0] w_ext;
  logic [CELLS-1:0] w_next;
  logic [IDXW-1:0]  w_idx_inc;
  logic [7:0]       w_byte_inc;
  logic             w_left_edge;
  logic             w_right_edge;

  // A seed byte enters at the top and pushes the register down one byte.
  assign w_seed_shift = {i_seed_byte, r_cells[CELLS-1:8]};
  // Generation 0 includes a seed byte accepted in the same cycle as start.
  assign w_gen0       = i_seed_valid ? w_seed_shift : r_cells;

  // Boundary cells: cell[CELLS] sits above the MSB, cell[-1] below the LSB.
  assign w_left_edge  = WRAP ? r_cells[0]       : 1'b0;
  assign w_right_edge = WRAP ? r_cells[CELLS-1] : 1'b0;
  assign w_ext        = {w_left_edge, r_cells, w_right_edge};

  // Rule 110: next = (c ^ r) | (c & ~l), with l = cell[i+1], r = cell[i-1].
  always_comb begin
    w_next = '0;
    for (int i = 0; i < CELLS; i++) begin
      w_next[i] = (w_ext[i+1] ^ w_ext[i]) | (w_ext[i+1] & ~w_ext[i+2]);
    end
  end

  assign w_idx_inc = r_idx + 1'b1;

  // Byte that will be presented after the current one is accepted.
  always_comb begin
    w_byte_inc = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (w_idx_inc == IDXW'(b)) begin
        w_byte_inc = r_cells[8*b +: 8];
      end
    end
  end

  // Sequencer: seed loading, byte transmission and generation stepping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cells      <= '0;
      r_idx        <= '0;
      r_remaining  <= '0;
      r_out_valid  <= 1'b0;
      r_out_byte   <= 8'h00;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_seed_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_seed_valid) begin
            r_cells <= w_seed_shift;
          end
          if (i_start) begin
            r_remaining  <= i_gens;
            r_idx        <= '0;
            r_out_byte   <= w_gen0[7:0];
            r_out_last   <= (NBYTES == 1);
            r_out_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_seed_ready <= 1'b0;
            r_state      <= S_SEND;
          end
        end

        S_SEND: begin
          if (i_out_ready) begin
            if (r_idx == LAST_IDX) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              if (r_remaining == 8'd0) begin
                r_busy       <= 1'b0;
                r_seed_ready <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_state <= S_STEP;
              end
            end else begin
              r_idx      <= w_idx_inc;
              r_out_byte <= w_byte_inc;
              r_out_last <= (w_idx_inc == LAST_IDX);
            end
          end
        end

        S_STEP: begin
          r_cells     <= w_next;
          r_remaining <= r_remaining - 8'd1;
          r_idx       <= '0;
          r_out_byte  <= w_next[7:0];
          r_out_last  <= (NBYTES == 1);
          r_out_valid <= 1'b1;
          r_state     <= S_SEND;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_seed_ready = r_seed_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_byte   = r_out_byte;
  assign o_out_last   = r_out_last;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_rule110_stream_tx.sv
// Directed bench for rule110_stream_tx. Two instances share stimulus: one
// with a zero boundary, one toroidal, so boundary behaviour is compared
// side by side while both stay in lockstep on the handshake.
module tb_rule110_stream_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_valid;
  logic [7:0] seed_byte;
  logic       start;
  logic [7:0] gens;
  logic       out_ready;

  logic       s_rdy0, ov0, ol0, busy0;
  logic [7:0] ob0;
  logic       s_rdy1, ov1, ol1, busy1;
  logic [7:0] ob1;

  int total = 0;
  int bad   = 0;

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic       gotl[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         cyc;
  int         gaps;

  rule110_stream_tx #(.CELLS(32), .WRAP(1'b0)) dut_nowrap (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_seed_valid (seed_valid),
    .i_seed_byte  (seed_byte),
    .o_seed_ready (s_rdy0),
    .i_start      (start),
    .i_gens       (gens),
    .o_out_valid  (ov0),
    .o_out_byte   (ob0),
    .o_out_last   (ol0),
    .i_out_ready  (out_ready),
    .o_busy       (busy0)
  );

  rule110_stream_tx #(.CELLS(32), .WRAP(1'b1)) dut_wrap (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_seed_valid (seed_valid),
    .i_seed_byte  (seed_byte),
    .o_seed_ready (s_rdy1),
    .i_start      (start),
    .i_gens       (gens),
    .o_out_valid  (ov1),
    .o_out_byte   (ob1),
    .o_out_last   (ol1),
    .i_out_ready  (out_ready),
    .o_busy       (busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed(input logic [7:0] b);
    seed_valid = 1'b1;
    seed_byte  = b;
    tick();
    seed_valid = 1'b0;
    seed_byte  = 8'h00;
  endtask

  task automatic do_start(input logic [7:0] g);
    start = 1'b1;
    gens  = g;
    tick();
    start = 1'b0;
    gens  = 8'hFF;
  endtask

  // Accept n bytes from both instances; with bp set, out_ready is random and
  // every stalled byte must still be presented unchanged on the next cycle.
  task automatic collect(input int n, input bit bp);
    logic [7:0] hold_b;
    logic       hold_l;
    bit         holding;
    holding = 1'b0;
    hold_b  = 8'h00;
    hold_l  = 1'b0;
    got0.delete();
    got1.delete();
    gotl.delete();
    cyc  = 0;
    gaps = 0;
    while (got0.size() < n && cyc < 2000) begin
      out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (holding) begin
        chk("bp_hold", {22'd0, ov0, ol0, ob0}, {22'd0, 1'b1, hold_l, hold_b});
        holding = 1'b0;
      end
      if (!ov0) gaps++;
      if (ov0 && out_ready) begin
        got0.push_back(ob0);
        got1.push_back(ob1);
        gotl.push_back(ol0);
      end else if (ov0) begin
        hold_b  = ob0;
        hold_l  = ol0;
        holding = 1'b1;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("collect_count", 32'(got0.size()), 32'(n));
  endtask

  task automatic check_stream(input string tag);
    for (int k = 0; k < exp0.size() && k < got0.size(); k++) begin
      chk($sformatf("%s_nowrap_b%0d", tag, k), 32'(got0[k]), 32'(exp0[k]));
      chk($sformatf("%s_wrap_b%0d", tag, k), 32'(got1[k]), 32'(exp1[k]));
      chk($sformatf("%s_last_b%0d", tag, k), 32'(gotl[k]), 32'((k % 4) == 3));
    end
  endtask

  initial begin
    rst        = 1'b1;
    seed_valid = 1'b0;
    seed_byte  = 8'h00;
    start      = 1'b0;
    gens       = 8'h00;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_outputs", {20'd0, s_rdy0, ov0, ol0, busy0, ob0}, {20'd0, 4'b1000, 8'h00});
    rst = 1'b0;
    tick();
    chk("idle_outputs", {20'd0, s_rdy0, ov0, ol0, busy0, ob0}, {20'd0, 4'b1000, 8'h00});

    // Basic evolution from a single live cell.
    seed(8'h01); seed(8'h00); seed(8'h00); seed(8'h00);
    do_start(8'd3);
    chk("valid_after_start", {30'd0, ov0, busy0}, {30'd0, 2'b11});
    collect(16, 1'b0);
    exp0 = '{8'h01,8'h00,8'h00,8'h00, 8'h03,8'h00,8'h00,8'h00,
             8'h07,8'h00,8'h00,8'h00, 8'h0D,8'h00,8'h00,8'h00};
    exp1 = exp0;
    check_stream("basic");
    chk("basic_latency", 32'(cyc), 32'd19);
    chk("basic_gaps", 32'(gaps), 32'd3);
    chk("basic_done", {30'd0, busy0, s_rdy0}, {30'd0, 2'b01});

    // Restart resends the last generation.
    do_start(8'd0);
    collect(4, 1'b0);
    exp0 = '{8'h0D,8'h00,8'h00,8'h00};
    exp1 = exp0;
    check_stream("restart");
    chk("restart_latency", 32'(cyc), 32'd4);
    tick();
    chk("restart_no_extra", {31'd0, ov0}, 32'd0);

    // Boundary: only the MSB cell is live.
    seed(8'h00); seed(8'h00); seed(8'h00); seed(8'h80);
    do_start(8'd1);
    collect(8, 1'b0);
    exp0 = '{8'h00,8'h00,8'h00,8'h80, 8'h00,8'h00,8'h00,8'h80};
    exp1 = '{8'h00,8'h00,8'h00,8'h80, 8'h01,8'h00,8'h00,8'h80};
    check_stream("wrap");
    chk("wrap_gaps", 32'(gaps), 32'd1);

    // Backpressure run reproduces the unstalled stream.
    seed(8'h01); seed(8'h00); seed(8'h00); seed(8'h00);
    do_start(8'd3);
    collect(16, 1'b1);
    exp0 = '{8'h01,8'h00,8'h00,8'h00, 8'h03,8'h00,8'h00,8'h00,
             8'h07,8'h00,8'h00,8'h00, 8'h0D,8'h00,8'h00,8'h00};
    exp1 = exp0;
    check_stream("bp");
    chk("bp_gaps", 32'(gaps), 32'd3);
    chk("bp_done", {31'd0, busy0}, 32'd0);

    // Seed and start pulsed while sending are ignored.
    seed(8'h01); seed(8'h00); seed(8'h00); seed(8'h00);
    do_start(8'd1);
    seed_valid = 1'b1;
    seed_byte  = 8'hFF;
    start      = 1'b1;
    gens       = 8'd5;
    chk("ign_seed_ready", {31'd0, s_rdy0}, 32'd0);
    tick();
    seed_valid = 1'b0;
    start      = 1'b0;
    seed_byte  = 8'h00;
    chk("ign_hold", {23'd0, ov0, ob0}, {23'd0, 1'b1, 8'h01});
    collect(8, 1'b0);
    exp0 = '{8'h01,8'h00,8'h00,8'h00, 8'h03,8'h00,8'h00,8'h00};
    exp1 = exp0;
    check_stream("ignore");
    chk("ign_done", {31'd0, busy0}, 32'd0);

    // Seed byte accepted in the start cycle lands in generation 0.
    seed(8'h00); seed(8'h00); seed(8'h00);
    seed_valid = 1'b1;
    seed_byte  = 8'hAA;
    do_start(8'd0);
    seed_valid = 1'b0;
    seed_byte  = 8'h00;
    collect(4, 1'b0);
    exp0 = '{8'h00,8'h00,8'h00,8'hAA};
    exp1 = exp0;
    check_stream("simul");

    // Asynchronous reset in the middle of a send.
    seed(8'h5A); seed(8'h11); seed(8'h22); seed(8'h33);
    do_start(8'd2);
    tick();
    chk("pre_rst", {22'd0, ov0, busy0, ob0}, {22'd0, 2'b11, 8'h5A});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {21'd0, ov0, busy0, ov1, ob0}, {21'd0, 3'b000, 8'h00});
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst", {30'd0, s_rdy0, busy0}, {30'd0, 2'b10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
